// File: rtl/aer_synapse_accumulator_pkg.sv
// Shared definitions for the AER synapse accumulator: FSM encoding, address helpers,
// the all-ones idle address and the saturating add used by the accumulators.
package aer_synapse_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_EMIT    = 2'd3
  } acc_state_e;

  localparam int SAT_W        = 32;
  localparam int DRAIN_CYCLES = 2;

  function automatic int aer_addr_w(input int n);
    return $clog2(n) + 1;
  endfunction

  // Bus value the transmitter drives when it has no event to send.
  function automatic logic [SAT_W-1:0] aer_idle_addr(input int n);
    logic [SAT_W-1:0] v;
    v = '0;
    for (int i = 0; i < aer_addr_w(n); i++) v[i] = 1'b1;
    return v;
  endfunction

  localparam int                   AER_NEURONS_DEF = 5;
  localparam int                   AER_ADDR_W_DEF  = aer_addr_w(AER_NEURONS_DEF);
  localparam logic [AER_ADDR_W_DEF-1:0] AER_IDLE_ADDR = '1;

  // Adds two sign-extended operands and clamps to the signed range of a w-bit result.
  function automatic logic signed [SAT_W-1:0] sat_add(input logic signed [SAT_W-1:0] a,
                                                     input logic signed [SAT_W-1:0] b,
                                                     input int unsigned             w);
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] lim;
    logic signed [SAT_W:0] max_v;
    logic signed [SAT_W:0] min_v;
    sum   = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    lim   = {{SAT_W{1'b0}}, 1'b1} << (w - 1);
    max_v = lim - (SAT_W+1)'(1);
    min_v = -lim;
    if (sum > max_v) return max_v[SAT_W-1:0];
    if (sum < min_v) return min_v[SAT_W-1:0];
    return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/aer_synapse_accumulator_weight_ram.sv
// Weight store: one row per source neuron, one w_width column per output neuron.
// Single synchronous write port (per column) and single synchronous read-before-write read port.
module aer_weight_ram #(
  parameter int ROWS    = 5,
  parameter int COLS    = 4,
  parameter int W_WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_we,
  input  logic [$clog2(ROWS)-1:0]   i_wr_row,
  input  logic [$clog2(COLS)-1:0]   i_wr_col,
  input  logic [W_WIDTH-1:0]        i_wr_data,
  input  logic [$clog2(ROWS)-1:0]   i_rd_row,
  output logic [COLS*W_WIDTH-1:0]   o_rd_data
);

  logic [COLS*W_WIDTH-1:0] r_mem [ROWS];
  logic [COLS*W_WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_we && (32'(i_wr_row) < 32'(ROWS)) && (32'(i_wr_col) < 32'(COLS)))
      r_mem[i_wr_row][i_wr_col*W_WIDTH +: W_WIDTH] <= i_wr_data;
    r_rd_data <= r_mem[i_rd_row];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/aer_synapse_accumulator.sv
// AER synapse accumulator: decodes burst addresses, sums weight rows, emits currents at burst end.
// Optional macro AER_EVENT_COUNT_EN adds event_count (accepted events in the last burst).
//
// state   | meaning
// IDLE    | no burst in progress, waiting for first accepted event
// COLLECT | burst running, accepted events flow through the pipeline
// DRAIN   | enable rose; waiting for the last events to leave the pipeline
// EMIT    | publish accumulators on currents, pulse current_valid, clear
module aer_synapse_accumulator
  import aer_synapse_accumulator_pkg::*;
#(
  parameter int no_of_neurons = 5,
  parameter int no_of_outputs = 4,
  parameter int w_width       = 8,
  parameter int acc_width     = 12
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [aer_addr_w(no_of_neurons)-1:0] AER_BUS,
  input  logic                                 neuron_enable,
  input  logic                                 w_we,
  input  logic [$clog2(no_of_neurons)-1:0]     w_src,
  input  logic [$clog2(no_of_outputs)-1:0]     w_dst,
  input  logic [w_width-1:0]                   w_data,
  output logic [no_of_outputs*acc_width-1:0]   currents,
  output logic                                 current_valid,
  output logic                                 busy,
  output logic                                 addr_error
`ifdef AER_EVENT_COUNT_EN
  ,
  output logic [$clog2(no_of_neurons*4):0]     event_count
`endif
);

  localparam int ADDR_W  = aer_addr_w(no_of_neurons);
  localparam int ROW_W   = $clog2(no_of_neurons);
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] IDLE_ADDR = ADDR_W'(aer_idle_addr(no_of_neurons));

  acc_state_e r_state, w_state_nxt;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic r_ne_q;
  logic w_in_burst, w_in_range, w_accept, w_bad, w_ne_rise, w_emit;
  logic r_s0_valid, r_s1_valid;
  logic [ROW_W-1:0] r_s0_row;
  logic [no_of_outputs*w_width-1:0] w_row_data;
  logic signed [acc_width-1:0] r_acc      [no_of_outputs];
  logic signed [acc_width-1:0] w_acc_base [no_of_outputs];
  logic signed [acc_width-1:0] w_acc_nxt  [no_of_outputs];
  logic [no_of_outputs*acc_width-1:0] w_acc_packed;
  logic [no_of_outputs*acc_width-1:0] r_currents;
  logic r_valid, r_addr_error;

  assign w_in_burst = !neuron_enable && (AER_BUS != IDLE_ADDR);
  assign w_in_range = (32'(AER_BUS) < 32'(no_of_neurons));
  assign w_accept   = w_in_burst && w_in_range;
  assign w_bad      = w_in_burst && !w_in_range;
  assign w_ne_rise  = neuron_enable && !r_ne_q;
  assign w_emit     = (r_state == ST_EMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ne_q     <= 1'b1;
      r_s0_valid <= 1'b0;
      r_s0_row   <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_ne_q     <= neuron_enable;
      r_s0_valid <= w_accept;
      if (w_accept) r_s0_row <= AER_BUS[ROW_W-1:0];
      r_s1_valid <= r_s0_valid;
    end
  end

  aer_weight_ram #(
    .ROWS    (no_of_neurons),
    .COLS    (no_of_outputs),
    .W_WIDTH (w_width)
  ) u_weight_ram (
    .i_clk     (clk),
    .i_we      (w_we),
    .i_wr_row  (w_src),
    .i_wr_col  (w_dst),
    .i_wr_data (w_data),
    .i_rd_row  (r_s0_row),
    .o_rd_data (w_row_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_state_nxt = ST_COLLECT;
      ST_COLLECT: if (w_ne_rise) w_state_nxt = ST_DRAIN;
      ST_DRAIN:   if (r_drain_cnt == '0) w_state_nxt = ST_EMIT;
      ST_EMIT:    w_state_nxt = w_accept ? ST_COLLECT : ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Preloaded while collecting so DRAIN lasts exactly DRAIN_CYCLES cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        r_drain_cnt <= '0;
    else if (r_state == ST_COLLECT)                   r_drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
    else if (r_state == ST_DRAIN && r_drain_cnt != '0) r_drain_cnt <= r_drain_cnt - 1'b1;
  end

  // An event landing on the EMIT cycle starts the next burst from zero.
  always_comb begin
    for (int j = 0; j < no_of_outputs; j++) begin
      w_acc_base[j] = w_emit ? '0 : r_acc[j];
      w_acc_nxt[j]  = w_acc_base[j];
      if (r_s1_valid)
        w_acc_nxt[j] = acc_width'(sat_add(SAT_W'(w_acc_base[j]),
                                          SAT_W'($signed(w_row_data[j*w_width +: w_width])),
                                          acc_width));
      w_acc_packed[j*acc_width +: acc_width] = r_acc[j];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < no_of_outputs; j++) r_acc[j] <= '0;
    end else begin
      for (int j = 0; j < no_of_outputs; j++) r_acc[j] <= w_acc_nxt[j];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_currents   <= '0;
      r_valid      <= 1'b0;
      r_addr_error <= 1'b0;
    end else begin
      r_valid <= w_emit;
      if (w_emit) r_currents <= w_acc_packed;
      if (w_bad)  r_addr_error <= 1'b1;
    end
  end

  assign currents      = r_currents;
  assign current_valid = r_valid;
  assign busy          = (r_state != ST_IDLE);
  assign addr_error    = r_addr_error;

`ifdef AER_EVENT_COUNT_EN
  localparam int EC_W = $clog2(no_of_neurons*4) + 1;
  logic [EC_W-1:0] r_evt_cnt;
  logic [EC_W-1:0] r_event_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_evt_cnt     <= '0;
      r_event_count <= '0;
    end else if (w_emit) begin
      r_event_count <= r_evt_cnt;
      r_evt_cnt     <= w_accept ? EC_W'(1) : '0;
    end else if (w_accept && r_evt_cnt != '1) begin
      r_evt_cnt <= r_evt_cnt + 1'b1;
    end
  end

  assign event_count = r_event_count;
`endif

endmodule

// File: tb/tb_aer_synapse_accumulator.sv
// Self-checking bench for aer_synapse_accumulator: table of bursts plus hand-written
// sequences for saturation, reset mid-burst and back-to-back bursts.
module tb_aer_synapse_accumulator;

  localparam int N    = 5;
  localparam int OUTS = 4;
  localparam int WW   = 8;
  localparam int ACC  = 12;
  localparam int AW   = 4;
  localparam int NMAX = 24;

  typedef logic [OUTS-1:0][15:0] cur_t;
  typedef struct packed {
    logic [7:0]            n;
    logic [NMAX-1:0][AW-1:0] addr;
    logic                  ev;
    logic                  err;
    cur_t                  cur;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] AER_BUS;
  logic neuron_enable;
  logic w_we;
  logic [2:0] w_src;
  logic [1:0] w_dst;
  logic [WW-1:0] w_data;
  logic [OUTS*ACC-1:0] currents;
  logic current_valid;
  logic busy;
  logic addr_error;
`ifdef AER_EVENT_COUNT_EN
  logic [5:0] event_count;
`endif

  always #5 clk = ~clk;

  aer_synapse_accumulator #(
    .no_of_neurons (N),
    .no_of_outputs (OUTS),
    .w_width       (WW),
    .acc_width     (ACC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .AER_BUS       (AER_BUS),
    .neuron_enable (neuron_enable),
    .w_we          (w_we),
    .w_src         (w_src),
    .w_dst         (w_dst),
    .w_data        (w_data),
    .currents      (currents),
    .current_valid (current_valid),
    .busy          (busy),
    .addr_error    (addr_error)
`ifdef AER_EVENT_COUNT_EN
    ,
    .event_count   (event_count)
`endif
  );

  cur_t sb[$];
  cur_t last_cur;
  int   n_cmp = 0;
  int   n_mis = 0;
  vec_t tbl[6];

  function automatic void chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endfunction

  function automatic int cur_of(input int j);
    return int'($signed(currents[j*ACC +: ACC]));
  endfunction

  function automatic vec_t mk(input int n, input int a0, input int a1, input int a2,
                              input bit ev, input bit err,
                              input int c0, input int c1, input int c2, input int c3);
    vec_t v;
    v = '0;
    for (int k = 0; k < NMAX; k++) v.addr[k] = '1;
    v.n = 8'(n);
    v.addr[0] = AW'(a0);
    v.addr[1] = AW'(a1);
    v.addr[2] = AW'(a2);
    v.ev  = ev;
    v.err = err;
    v.cur[0] = 16'(c0);
    v.cur[1] = 16'(c1);
    v.cur[2] = 16'(c2);
    v.cur[3] = 16'(c3);
    return v;
  endfunction

  function automatic vec_t mk_rep(input int n, input int a, input int c);
    vec_t v;
    v = mk(0, 15, 15, 15, 1'b1, 1'b0, c, c, c, c);
    v.n = 8'(n);
    for (int k = 0; k < n; k++) v.addr[k] = AW'(a);
    return v;
  endfunction

  task automatic wr(input int s, input int d, input int val);
    w_we   = 1'b1;
    w_src  = 3'(s);
    w_dst  = 2'(d);
    w_data = WW'(val);
    @(negedge clk);
    w_we   = 1'b0;
  endtask

  task automatic wr_row(input int s, input int c0, input int c1, input int c2, input int c3);
    wr(s, 0, c0);
    wr(s, 1, c1);
    wr(s, 2, c2);
    wr(s, 3, c3);
  endtask

  // Drives one burst, then watches for the current_valid pulse within a bounded window.
  task automatic run(input vec_t v, input bit gap);
    int   k_seen;
    logic busy_before;
    cur_t e;
`ifdef AER_EVENT_COUNT_EN
    int   n_ok;
    n_ok = 0;
    for (int i = 0; i < int'(v.n); i++) if (int'(v.addr[i]) < N) n_ok++;
`endif
    neuron_enable = 1'b0;
    for (int i = 0; i < int'(v.n); i++) begin
      AER_BUS = v.addr[i];
      @(negedge clk);
    end
    AER_BUS = '1;
    @(negedge clk);
    neuron_enable = 1'b1;
    if (v.ev) begin
      sb.push_back(v.cur);
      last_cur = v.cur;
    end
    k_seen      = 0;
    busy_before = 1'b0;
    for (int k = 1; k <= 12 && k_seen == 0; k++) begin
      @(negedge clk);
      if (current_valid) begin
        k_seen = k;
        chk("busy_at_valid", int'(busy), 0);
        chk("busy_before_valid", int'(busy_before), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          for (int j = 0; j < OUTS; j++) chk($sformatf("currents[%0d]", j), cur_of(j), int'($signed(e[j])));
        end
`ifdef AER_EVENT_COUNT_EN
        chk("event_count", int'(event_count), n_ok);
`endif
      end else begin
        busy_before = busy;
      end
    end
    chk("valid_latency", k_seen, v.ev ? 4 : 0);
    chk("addr_error", int'(addr_error), int'(v.err));
    if (!v.ev) begin
      chk("busy_idle", int'(busy), 0);
      for (int j = 0; j < OUTS; j++) chk($sformatf("currents_hold[%0d]", j), cur_of(j), int'($signed(last_cur[j])));
    end
    if (gap) begin
      @(negedge clk);
      chk("valid_pulse_width", int'(current_valid), 0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   vsn;
    vec_t v;
    last_cur      = '0;
    reset         = 1'b1;
    AER_BUS       = '1;
    neuron_enable = 1'b1;
    w_we          = 1'b0;
    w_src         = '0;
    w_dst         = '0;
    w_data        = '0;
    tbl[0] = mk(2, 0, 3, 15, 1'b1, 1'b0,  -4,  2,   8,   14);
    tbl[1] = mk(3, 0, 0, 0,  1'b1, 1'b0,   3,  6,   9,   12);
    tbl[2] = mk(2, 6, 2, 15, 1'b1, 1'b1,   7, -7, 100, -100);
    tbl[3] = mk(3, 4, 2, 3,  1'b1, 1'b1,   1, -8, 104,  -91);
    tbl[4] = mk(0, 15, 15, 15, 1'b0, 1'b1, 0,  0,   0,    0);
    tbl[5] = mk(2, 6, 7, 15, 1'b0, 1'b1,   0,  0,   0,    0);

    repeat (2) @(negedge clk);
    chk("rst_currents", int'(currents != '0), 0);
    chk("rst_valid", int'(current_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_addr_error", int'(addr_error), 0);
    reset = 1'b0;
    @(negedge clk);

    wr_row(0, 1, 2, 3, 4);
    wr_row(1, 0, 0, 0, 0);
    wr_row(2, 7, -7, 100, -100);
    wr_row(3, -5, 0, 5, 10);
    wr_row(4, -1, -1, -1, -1);

    for (int t = 0; t < 6; t++) run(tbl[t], 1'b1);

    // Reset in the middle of a burst: the two pre-reset events must vanish.
    neuron_enable = 1'b0;
    AER_BUS = 4'd0;
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b1;
    AER_BUS = '1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_currents", int'(currents != '0), 0);
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_addr_error", int'(addr_error), 0);
    vsn = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (current_valid) vsn = 1;
    end
    chk("midrst_no_valid", vsn, 0);
    last_cur = '0;
    run(mk(1, 3, 15, 15, 1'b1, 1'b0, -5, 0, 5, 10), 1'b1);

    // Saturation in both directions.
    wr_row(1, 127, 127, 127, 127);
    run(mk_rep(20, 1, 2047), 1'b1);
    wr_row(1, -128, -128, -128, -128);
    run(mk_rep(20, 1, -2048), 1'b1);

    // Back-to-back bursts: the second starts the cycle right after EMIT.
    run(mk(1, 4, 15, 15, 1'b1, 1'b0, -1, -1, -1, -1), 1'b0);
    run(mk(1, 0, 15, 15, 1'b1, 1'b0,  1,  2,  3,  4), 1'b1);

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
